dv_frame_packer: RTL and testbench

//  Downstream consumer of the case-driven pattern generator's dv/data byte stream.

---
 rtl/dv_frame_packer_if.sv | 14 +
 rtl/dv_frame_packer.sv | 157 +++++++++++++++
 tb/tb_dv_frame_packer.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/dv_frame_packer_if.sv
// dv_frame_packer_if: framed output word stream with valid/ready handshake.
// The master drives the word and its frame tags; the slave returns ready.
interface dv_frame_packer_if #(
  parameter int DW = 8
);
  logic          valid;
  logic          ready;
  logic [DW-1:0] data;
  logic          sof;
  logic          eof;

  modport master (output valid, data, sof, eof, input ready);
  modport slave  (input valid, data, sof, eof, output ready);
endinterface

// File: rtl/dv_frame_packer.sv
// dv_frame_packer: groups accepted dv bytes into FRAME_LEN-byte frames held in a
// store-and-forward FIFO. Writes advance a speculative pointer; a frame becomes
// visible only when its last byte commits. A frame hit by overflow is rolled back
// and dropped whole.
// Optional feature macro: CHECKSUM_EN appends one mod-256 sum word per frame.
//
// state | meaning
// FILL  | accepting bytes of the current frame into the FIFO
// DROP  | discarding the remainder of a frame that overflowed
module dv_frame_packer #(
  parameter int FRAME_LEN  = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int DW         = 8
) (
  input  logic              sclk,
  input  logic              rst,
  input  logic              i_dv,
  input  logic [DW-1:0]     i_data,
  dv_frame_packer_if.master m_if,
  output logic              o_ovf,
  output logic [15:0]       o_frame_cnt,
  output logic [7:0]        o_drop_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int BW = $clog2(FRAME_LEN);
  localparam int EW = DW + 2;
  localparam logic [BW-1:0] LAST    = BW'(FRAME_LEN - 1);
  localparam logic [PW-1:0] DEPTH_P = PW'(FIFO_DEPTH);

  typedef enum logic {FILL, DROP} state_t;

  state_t        state;
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, cm_ptr, rd_ptr;
  logic [BW-1:0] bcnt;
  logic [PW-1:0] used;
  logic [PW-1:0] wr_ptr_adv;
  logic          last_byte;
  logic          has_space;
  logic          fill_wr;
  logic          rd_fire;
  logic [EW-1:0] rd_word;

  // Occupancy includes uncommitted words so a partial frame cannot overrun unread data.
  assign used      = wr_ptr - rd_ptr;
  assign last_byte = (bcnt == LAST);

`ifdef CHECKSUM_EN
  logic [DW-1:0] sum;
  logic [DW-1:0] sum_next;
  logic [PW-1:0] wr_ptr_p1;

  assign sum_next   = sum + i_data;
  assign wr_ptr_p1  = wr_ptr + PW'(1);
  // The last byte lands together with its checksum word, so it needs two free slots.
  assign has_space  = last_byte ? (used <= (DEPTH_P - PW'(2))) : (used < DEPTH_P);
  assign wr_ptr_adv = last_byte ? (wr_ptr + PW'(2)) : wr_ptr_p1;
`else
  assign has_space  = (used < DEPTH_P);
  assign wr_ptr_adv = wr_ptr + PW'(1);
`endif

  assign fill_wr = (state == FILL) && i_dv && has_space;

  // First-word-fall-through read side; valid depends only on registered pointers.
  assign rd_word    = mem[rd_ptr[AW-1:0]];
  assign m_if.valid = (rd_ptr != cm_ptr);
  assign m_if.data  = rd_word[DW-1:0];
  assign m_if.eof   = rd_word[DW];
  assign m_if.sof   = rd_word[DW+1];
  assign rd_fire    = m_if.valid & m_if.ready;

  // FIFO storage: entries are {sof, eof, data}; cleared on reset so outputs read 0.
  always_ff @(posedge sclk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (fill_wr) begin
`ifdef CHECKSUM_EN
      mem[wr_ptr[AW-1:0]] <= {(bcnt == '0), 1'b0, i_data};
      if (last_byte) begin
        mem[wr_ptr_p1[AW-1:0]] <= {1'b0, 1'b1, sum_next};
      end
`else
      mem[wr_ptr[AW-1:0]] <= {(bcnt == '0), last_byte, i_data};
`endif
    end
  end

  // Frame FSM, pointers and status counters.
  always_ff @(posedge sclk) begin
    if (rst) begin
      state       <= FILL;
      wr_ptr      <= '0;
      cm_ptr      <= '0;
      rd_ptr      <= '0;
      bcnt        <= '0;
      o_ovf       <= 1'b0;
      o_frame_cnt <= '0;
      o_drop_cnt  <= '0;
`ifdef CHECKSUM_EN
      sum         <= '0;
`endif
    end else begin
      if (rd_fire) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (i_dv) begin
        case (state)
          FILL: begin
            if (has_space) begin
              wr_ptr <= wr_ptr_adv;
              if (last_byte) begin
                bcnt        <= '0;
                cm_ptr      <= wr_ptr_adv;
                o_frame_cnt <= o_frame_cnt + 16'd1;
`ifdef CHECKSUM_EN
                sum         <= '0;
`endif
              end else begin
                bcnt <= bcnt + BW'(1);
`ifdef CHECKSUM_EN
                sum  <= sum_next;
`endif
              end
            end else begin
              o_ovf  <= 1'b1;
              wr_ptr <= cm_ptr;
`ifdef CHECKSUM_EN
              sum    <= '0;
`endif
              if (last_byte) begin
                bcnt <= '0;
                if (o_drop_cnt != 8'hFF) o_drop_cnt <= o_drop_cnt + 8'd1;
              end else begin
                bcnt  <= bcnt + BW'(1);
                state <= DROP;
              end
            end
          end
          DROP: begin
            if (last_byte) begin
              bcnt  <= '0;
              state <= FILL;
              if (o_drop_cnt != 8'hFF) o_drop_cnt <= o_drop_cnt + 8'd1;
            end else begin
              bcnt <= bcnt + BW'(1);
            end
          end
          default: state <= FILL;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_dv_frame_packer.sv
// tb_dv_frame_packer: directed checks of framing, overflow rollback, reset and
// handshake behaviour for the default build (FRAME_LEN=4, FIFO_DEPTH=8).
module tb_dv_frame_packer;
  logic        sclk = 1'b0;
  logic        rst;
  logic        i_dv;
  logic [7:0]  i_data;
  logic        o_ovf;
  logic [15:0] o_frame_cnt;
  logic [7:0]  o_drop_cnt;
  int          n_cmp = 0;
  int          n_err = 0;

  dv_frame_packer_if #(.DW(8)) m_if ();

  dv_frame_packer #(.FRAME_LEN(4), .FIFO_DEPTH(8), .DW(8)) dut (
    .sclk        (sclk),
    .rst         (rst),
    .i_dv        (i_dv),
    .i_data      (i_data),
    .m_if        (m_if),
    .o_ovf       (o_ovf),
    .o_frame_cnt (o_frame_cnt),
    .o_drop_cnt  (o_drop_cnt)
  );

  always #5 sclk = ~sclk;

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    i_dv   = 1'b1;
    i_data = b;
    tick();
    i_dv   = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] base);
    for (int k = 0; k < 4; k++) send(8'(base + 8'(k)));
  endtask

  task automatic chk_word(input string tag, input logic [7:0] d, input logic s, input logic e);
    chk({tag, ".valid"}, 32'(m_if.valid), 32'd1);
    chk({tag, ".data"},  32'(m_if.data),  32'(d));
    chk({tag, ".sof"},   32'(m_if.sof),   32'(s));
    chk({tag, ".eof"},   32'(m_if.eof),   32'(e));
  endtask

  // Drains one frame with ready held high, checking each word and its tags.
  task automatic expect_frame(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3);
    m_if.ready = 1'b1;
    chk_word({tag, ".w0"}, b0, 1'b1, 1'b0); tick();
    chk_word({tag, ".w1"}, b1, 1'b0, 1'b0); tick();
    chk_word({tag, ".w2"}, b2, 1'b0, 1'b0); tick();
    chk_word({tag, ".w3"}, b3, 1'b0, 1'b1); tick();
  endtask

  initial begin
    logic [5:0] dv_pat;
    int         j;
    int         idx;
    logic       fire;

    rst = 1'b1; i_dv = 1'b0; i_data = 8'h00; m_if.ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst.valid", 32'(m_if.valid), 32'd0);
    chk("rst.data",  32'(m_if.data),  32'd0);
    chk("rst.ovf",   32'(o_ovf),      32'd0);
    chk("rst.frame", 32'(o_frame_cnt), 32'd0);
    chk("rst.drop",  32'(o_drop_cnt), 32'd0);

    // T1: single frame with ready high
    m_if.ready = 1'b1;
    send(8'h07); send(8'h00); send(8'h05);
    chk("t1.not_yet", 32'(m_if.valid), 32'd0);
    send(8'h07);
    chk("t1.frame", 32'(o_frame_cnt), 32'd1);
    expect_frame("t1", 8'h07, 8'h00, 8'h05, 8'h07);
    chk("t1.empty", 32'(m_if.valid), 32'd0);

    // T2: three frames into an 8-deep FIFO with ready low
    m_if.ready = 1'b0;
    send_frame(8'h10);
    chk_word("t2.hold", 8'h10, 1'b1, 1'b0);
    send_frame(8'h20);
    send_frame(8'h30);
    chk_word("t2.stable", 8'h10, 1'b1, 1'b0);
    chk("t2.frame", 32'(o_frame_cnt), 32'd3);
    chk("t2.drop",  32'(o_drop_cnt),  32'd1);
    chk("t2.ovf",   32'(o_ovf),       32'd1);

    // T3: one free slot, overflow on the second byte of a frame
    m_if.ready = 1'b1;
    tick();
    m_if.ready = 1'b0;
    chk_word("t3.head", 8'h11, 1'b0, 1'b0);
    send_frame(8'h40);
    chk("t3.drop",  32'(o_drop_cnt),  32'd2);
    chk("t3.frame", 32'(o_frame_cnt), 32'd3);
    m_if.ready = 1'b1;
    chk_word("t3.a1", 8'h11, 1'b0, 1'b0); tick();
    chk_word("t3.a2", 8'h12, 1'b0, 1'b0); tick();
    chk_word("t3.a3", 8'h13, 1'b0, 1'b1); tick();
    expect_frame("t3.b", 8'h20, 8'h21, 8'h22, 8'h23);
    chk("t3.no_partial", 32'(m_if.valid), 32'd0);
    send_frame(8'h50);
    expect_frame("t3.e", 8'h50, 8'h51, 8'h52, 8'h53);
    chk("t3.empty", 32'(m_if.valid), 32'd0);
    chk("t3.frame2", 32'(o_frame_cnt), 32'd4);

    // T4: reset mid-frame with two committed words pending
    m_if.ready = 1'b0;
    send_frame(8'h60);
    m_if.ready = 1'b1;
    tick(); tick();
    m_if.ready = 1'b0;
    chk_word("t4.pend", 8'h62, 1'b0, 1'b0);
    send(8'h70); send(8'h71);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t4.valid", 32'(m_if.valid),  32'd0);
    chk("t4.data",  32'(m_if.data),   32'd0);
    chk("t4.frame", 32'(o_frame_cnt), 32'd0);
    chk("t4.drop",  32'(o_drop_cnt),  32'd0);
    chk("t4.ovf",   32'(o_ovf),       32'd0);
    m_if.ready = 1'b1;
    send_frame(8'h80);
    expect_frame("t4.next", 8'h80, 8'h81, 8'h82, 8'h83);
    chk("t4.frame2", 32'(o_frame_cnt), 32'd1);

    // T5: gapped input with ready toggling, scoreboard on the output
    dv_pat = 6'b101101;
    j = 0;
    for (int k = 0; k < 6; k++) begin
      m_if.ready = k[0];
      i_dv       = dv_pat[k];
      i_data     = dv_pat[k] ? 8'(8'h90 + 8'(j)) : 8'hEE;
      if (dv_pat[k]) j++;
      tick();
      i_dv = 1'b0;
      if (k < 5) chk("t5.pre_commit", 32'(m_if.valid), 32'd0);
    end
    chk("t5.commit", 32'(m_if.valid), 32'd1);
    idx = 0;
    for (int c = 0; c < 20 && idx < 4; c++) begin
      if (m_if.valid) begin
        chk("t5.data", 32'(m_if.data), 32'(8'h90 + 8'(idx)));
        chk("t5.sof",  32'(m_if.sof),  32'(idx == 0));
        chk("t5.eof",  32'(m_if.eof),  32'(idx == 3));
      end
      m_if.ready = c[0];
      fire = m_if.valid & m_if.ready;
      tick();
      if (fire) idx++;
    end
    chk("t5.count", 32'(idx), 32'd4);
    chk("t5.empty", 32'(m_if.valid), 32'd0);
    chk("t5.frame", 32'(o_frame_cnt), 32'd2);

    // T7: overflow exactly on the last byte of a frame
    m_if.ready = 1'b0;
    send_frame(8'hA0);
    m_if.ready = 1'b1;
    tick(); tick(); tick();
    m_if.ready = 1'b0;
    chk_word("t7.a3", 8'hA3, 1'b0, 1'b1);
    send_frame(8'hB0);
    send_frame(8'hC0);
    chk("t7.drop",  32'(o_drop_cnt),  32'd1);
    chk("t7.ovf",   32'(o_ovf),       32'd1);
    chk("t7.frame", 32'(o_frame_cnt), 32'd4);
    m_if.ready = 1'b1;
    chk_word("t7.a3b", 8'hA3, 1'b0, 1'b1); tick();
    expect_frame("t7.b", 8'hB0, 8'hB1, 8'hB2, 8'hB3);
    chk("t7.rolled_back", 32'(m_if.valid), 32'd0);
    send_frame(8'hD0);
    expect_frame("t7.d", 8'hD0, 8'hD1, 8'hD2, 8'hD3);
    chk("t7.frame2", 32'(o_frame_cnt), 32'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
